// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving an external shared
// 32-bit add/subtract unit; one shift-add or restoring-subtract step per cycle.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] as_a,
    output logic [XLEN-1:0] as_b,
    output logic            as_sub,
    input  logic [XLEN-1:0] as_out
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      op_reg;
    logic [XLEN-1:0] opb_reg;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mq;

    logic [XLEN-1:0] shifted;
    logic            carry;
    logic            borrow;

    // The adder has no carry/borrow out, so both are rebuilt from the operand
    // and sum sign bits.
    always_comb begin
        as_a    = '0;
        as_b    = '0;
        as_sub  = 1'b0;
        shifted = {acc[XLEN-2:0], mq[XLEN-1]};
        if (state == RUN) begin
            if (!op_reg[1]) begin
                as_a = acc;
                as_b = mq[0] ? opb_reg : '0;
            end else begin
                as_sub = 1'b1;
                as_a   = shifted;
                as_b   = opb_reg;
            end
        end
        carry  = (as_a[XLEN-1] & as_b[XLEN-1]) |
                 ((as_a[XLEN-1] | as_b[XLEN-1]) & ~as_out[XLEN-1]);
        borrow = ~acc[XLEN-1] &
                 ((~as_a[XLEN-1] & as_b[XLEN-1]) |
                  (~(as_a[XLEN-1] ^ as_b[XLEN-1]) & as_out[XLEN-1]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            op_reg  <= '0;
            opb_reg <= '0;
            acc     <= '0;
            mq      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg  <= op;
                        opb_reg <= opb;
                        acc     <= '0;
                        mq      <= opa;
                        count   <= CW'(ITER - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!op_reg[1]) begin
                        acc <= {carry, as_out[XLEN-1:1]};
                        mq  <= {as_out[0], mq[XLEN-1:1]};
                    end else begin
                        acc <= borrow ? shifted : as_out;
                        mq  <= {mq[XLEN-2:0], ~borrow};
                    end
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    // MULHU and REMU both live in acc; MUL and DIVU in mq.
                    result <= op_reg[0] ? acc : mq;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
